axis_mult_arbiter: RTL and testbench
====================================

Name: axis_mult_arbiter

Overview:
- Packet-level round-robin arbiter that shares one axis_multiplier instance between NUM_SRC independent 128-bit AXI-Stream sources.
- Holds one programmable weight per source and presents the granted source's weight on the multiplier's weight input, constant for the whole packet.
- Sits between the ADC-side stream sources and the multiplier's s_axis port. Emits the source index so downstream S2MM logic can route results.

Parameters:
- NUM_SRC, 4, number of requesting streams (2..8)
- IDX_WIDTH, 2, source index width; equals clog2(NUM_SRC)
- SDATA_WIDTH, 128, stream data width per source
- WEIGHT_WIDTH, 8, weight width
- WEIGHT_RST, 0, reset value of every weight register

Ports:
- CLK  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  NUM_SRC  per-source valid
- s_axis_tready  out  NUM_SRC  per-source ready
- s_axis_tdata  in  NUM_SRC*SDATA_WIDTH  source k occupies bits [k*SDATA_WIDTH +: SDATA_WIDTH]
- s_axis_tlast  in  NUM_SRC  per-source end of packet
- wgt_wr_en  in  1  weight write strobe
- wgt_wr_idx  in  IDX_WIDTH  weight register to write
- wgt_wr_data  in  WEIGHT_WIDTH  weight value
- m_axis_tvalid  out  1  to multiplier s_axis_tvalid
- m_axis_tready  in  1  from multiplier s_axis_tready
- m_axis_tdata  out  SDATA_WIDTH  to multiplier s_axis_tdata
- m_axis_tlast  out  1  to multiplier s_axis_tlast
- m_axis_tid  out  IDX_WIDTH  source index of the current beat
- m_weight  out  WEIGHT_WIDTH  to multiplier bWeight
- busy  out  1  high while in state LOCK
- pkt_count  out  16  count of completed packets; wraps

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE; rr_ptr=NUM_SRC-1, so the first grant goes to source 0.
  - All weights = WEIGHT_RST.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, m_weight=WEIGHT_RST.
  - s_axis_tready=0, busy=0, pkt_count=0.
- States:
  - IDLE: if any s_axis_tvalid is high, grant the first requester searching from rr_ptr+1 modulo NUM_SRC. Latch gnt and active_wgt=weight[gnt]; go to LOCK. This costs one arbitration cycle; no beat is accepted in IDLE.
  - LOCK: s_axis_tready[gnt] = !m_axis_tvalid || m_axis_tready. All other tready bits are 0.
  - On an accepted beat (tvalid && tready on gnt) with tlast=1: rr_ptr<=gnt, pkt_count++, go to IDLE.
- Output register:
  - A single registered stage. An accepted beat loads tdata, tlast, tid=gnt and m_weight=active_wgt, and sets m_axis_tvalid.
  - m_axis_tvalid clears when m_axis_tready=1 and no new beat is accepted that cycle.
  - Latency from source beat to output is 1 cycle. Full throughput inside a packet.
  - While m_axis_tvalid=1 and m_axis_tready=0, the outputs stay stable.
- Weights:
  - wgt_wr_en writes weight[wgt_wr_idx] on the clock edge.
  - active_wgt is sampled only at grant time, so a write to the locked source takes effect on that source's next packet.
  - A write in the same cycle as the grant: the grant uses the old value.
  - wgt_wr_idx >= NUM_SRC is ignored.
- Boundary conditions:
  - Locked source drops tvalid mid-packet: hold the lock indefinitely; no timeout.
  - Single-beat packet (tlast on the first beat): LOCK lasts one accepted cycle.
  - Only one requester active: it is re-granted after its one IDLE bubble per packet.
  - Reset mid-packet: everything returns to reset values and the partial packet is dropped.

Decomposition:
- Package axis_mult_pkg: NUM_SRC, IDX_WIDTH, SDATA_WIDTH, WEIGHT_WIDTH defaults; state enum {IDLE, LOCK}.
- Sub-module rr_arbiter: combinational round-robin pick of (req vector, rr_ptr) giving grant index and any_req. It is reused by later multi-channel blocks.

Test Plan:
- Reset, then write weight[2]=8'h40; source 2 sends 3 beats, last tlast=1, m_axis_tready=1 -> s_axis_tready[2] asserts 1 cycle after tvalid. Outputs follow 1 cycle later with m_axis_tid=2 and m_weight=8'h40 on all 3 beats; pkt_count=1.
- Sources 0,1,3 each hold a 2-beat packet simultaneously -> grant order 0,1,3 with one IDLE cycle between packets; other sources' tready stays 0 throughout.
- m_axis_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; outputs stable while stalled; source sees tready=0 while the output register is full and stalled.
- While locked on source 1 (weight 8'h10), write weight[1]=8'h20 -> remaining beats carry 8'h10; the next source-1 packet carries 8'h20.
- Assert resetn low asynchronously mid-packet -> all outputs reach reset values before the next CLK edge; after release, source 0 is granted first.
- Source 0 requests continuously with 1-beat packets while source 3 requests once -> source 3 is granted after at most one source-0 packet.

Source files
------------

// File: rtl/axis_mult_pkg.sv
// Shared defaults and state encoding for the multiplier stream arbiter and its helpers.
package axis_mult_pkg;

  localparam int unsigned DefNumSrc      = 4;
  localparam int unsigned DefIdxWidth    = 2;
  localparam int unsigned DefSdataWidth  = 128;
  localparam int unsigned DefWeightWidth = 8;

  typedef enum logic {
    StIdle,
    StLock
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr_i, wrapping modulo NUM_SRC.
module rr_arbiter
  import axis_mult_pkg::*;
#(
  parameter int unsigned NUM_SRC   = DefNumSrc,
  parameter int unsigned IDX_WIDTH = DefIdxWidth
) (
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [IDX_WIDTH-1:0] ptr_i,
  output logic [IDX_WIDTH-1:0] gnt_o,
  output logic                 any_req_o
);

  int unsigned sel;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o     = '0;
    any_req_o = |req_i;
    sel       = 0;
    for (int unsigned i = NUM_SRC; i >= 1; i--) begin
      sel = (32'(ptr_i) + i) % NUM_SRC;
      if (req_i[sel[IDX_WIDTH-1:0]]) begin
        gnt_o = sel[IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_mult_arbiter.sv
// Packet-level round-robin arbiter sharing one multiplier between several AXI-Stream sources,
// with a per-source weight held constant for the whole granted packet.
module axis_mult_arbiter
  import axis_mult_pkg::*;
#(
  parameter int unsigned NUM_SRC      = DefNumSrc,
  parameter int unsigned IDX_WIDTH    = DefIdxWidth,
  parameter int unsigned SDATA_WIDTH  = DefSdataWidth,
  parameter int unsigned WEIGHT_WIDTH = DefWeightWidth,
  parameter int unsigned WEIGHT_RST   = 0
) (
  input  logic                           CLK,
  input  logic                           resetn,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*SDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  input  logic                           wgt_wr_en,
  input  logic [IDX_WIDTH-1:0]           wgt_wr_idx,
  input  logic [WEIGHT_WIDTH-1:0]        wgt_wr_data,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [SDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic [IDX_WIDTH-1:0]           m_axis_tid,
  output logic [WEIGHT_WIDTH-1:0]        m_weight,
  output logic                           busy,
  output logic [15:0]                    pkt_count
);

  localparam logic [IDX_WIDTH-1:0]    LastIdx = IDX_WIDTH'(NUM_SRC - 1);
  localparam logic [WEIGHT_WIDTH-1:0] WgtRst  = WEIGHT_WIDTH'(WEIGHT_RST);

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, arb_gnt;
  logic                    any_req;
  logic [WEIGHT_WIDTH-1:0] wgt_q [NUM_SRC];
  logic [WEIGHT_WIDTH-1:0] wgt_d [NUM_SRC];
  logic [WEIGHT_WIDTH-1:0] active_wgt_q, active_wgt_d;
  logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [SDATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [IDX_WIDTH-1:0]    m_tid_q, m_tid_d;
  logic [WEIGHT_WIDTH-1:0] m_wgt_q, m_wgt_d;
  logic [15:0]             pkt_q, pkt_d;

  logic                   src_valid, src_last, out_ready, accept;
  logic [SDATA_WIDTH-1:0] src_data;

  rr_arbiter #(
    .NUM_SRC  (NUM_SRC),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_rr_arbiter (
    .req_i    (s_axis_tvalid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .any_req_o(any_req)
  );

  assign src_valid = s_axis_tvalid[gnt_q];
  assign src_last  = s_axis_tlast[gnt_q];
  assign src_data  = s_axis_tdata[gnt_q*SDATA_WIDTH +: SDATA_WIDTH];
  assign out_ready = !m_valid_q || m_axis_tready;
  assign accept    = (state_q == StLock) && src_valid && out_ready;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == StLock) begin
      s_axis_tready[gnt_q] = out_ready;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_ptr_d     = rr_ptr_q;
    active_wgt_d = active_wgt_q;
    pkt_d        = pkt_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    m_tid_d      = m_tid_q;
    m_wgt_d      = m_wgt_q;
    wgt_d        = wgt_q;

    if (wgt_wr_en && (32'(wgt_wr_idx) < NUM_SRC)) begin
      wgt_d[wgt_wr_idx] = wgt_wr_data;
    end

    unique case (state_q)
      StIdle: begin
        // Grant reads the registered weight, so a same-cycle write lands next packet.
        if (any_req) begin
          gnt_d        = arb_gnt;
          active_wgt_d = wgt_q[arb_gnt];
          state_d      = StLock;
        end
      end
      StLock: begin
        if (accept && src_last) begin
          rr_ptr_d = gnt_q;
          pkt_d    = pkt_q + 16'd1;
          state_d  = StIdle;
        end
      end
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = src_data;
      m_last_d  = src_last;
      m_tid_d   = gnt_q;
      m_wgt_d   = active_wgt_q;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      rr_ptr_q     <= LastIdx;
      active_wgt_q <= WgtRst;
      pkt_q        <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      m_tid_q      <= '0;
      m_wgt_q      <= WgtRst;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wgt_q[i] <= WgtRst;
      end
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      active_wgt_q <= active_wgt_d;
      pkt_q        <= pkt_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      m_tid_q      <= m_tid_d;
      m_wgt_q      <= m_wgt_d;
      wgt_q        <= wgt_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tid    = m_tid_q;
  assign m_weight      = m_wgt_q;
  assign busy          = (state_q == StLock);
  assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_mult_arbiter.sv
// Directed bench for axis_mult_arbiter; source beats carry {src, seq} in their low 16 data bits.
module tb_axis_mult_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;

  logic            CLK = 1'b0;
  logic            resetn = 1'b1;
  logic [N-1:0]    s_axis_tvalid = '0;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata = '0;
  logic [N-1:0]    s_axis_tlast = '0;
  logic            wgt_wr_en = 1'b0;
  logic [1:0]      wgt_wr_idx = '0;
  logic [7:0]      wgt_wr_data = '0;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast;
  logic [1:0]      m_axis_tid;
  logic [7:0]      m_weight;
  logic            busy;
  logic [15:0]     pkt_count;

  int total = 0;
  int bad   = 0;
  int beats_left [N];
  int seq [N];
  bit rpt [N];

  axis_mult_arbiter dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .wgt_wr_en    (wgt_wr_en),
    .wgt_wr_idx   (wgt_wr_idx),
    .wgt_wr_data  (wgt_wr_data),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tid   (m_axis_tid),
    .m_weight     (m_weight),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] data, input logic last,
                         input logic [1:0] tid, input logic [7:0] wgt);
    chk({tag, ".valid"}, DW'(m_axis_tvalid), DW'(1'b1));
    chk({tag, ".data"}, m_axis_tdata, DW'(data));
    chk({tag, ".last"}, DW'(m_axis_tlast), DW'(last));
    chk({tag, ".tid"}, DW'(m_axis_tid), DW'(tid));
    chk({tag, ".wgt"}, DW'(m_weight), DW'(wgt));
  endtask

  task automatic drive(input int k);
    s_axis_tvalid[k]          = (beats_left[k] > 0);
    s_axis_tlast[k]           = (beats_left[k] == 1);
    s_axis_tdata[k*DW +: DW]  = DW'((k << 8) | seq[k]);
  endtask

  task automatic start_pkt(input int k, input int len);
    beats_left[k] = len;
    drive(k);
  endtask

  // One clock: record handshakes before the edge, advance source models after it.
  task automatic tick();
    logic [N-1:0] acc;
    acc = s_axis_tvalid & s_axis_tready;
    @(posedge CLK);
    #2;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        seq[k]++;
        beats_left[k]--;
        if (beats_left[k] == 0 && rpt[k]) beats_left[k] = 1;
        drive(k);
      end
    end
    #1;
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < N; k++) begin
      beats_left[k] = 0;
      rpt[k]        = 1'b0;
      drive(k);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      seq[k] = 0;
    end
    clear_srcs();
    #1 resetn = 1'b0;
    tick();
    tick();
    chk("rst.valid", DW'(m_axis_tvalid), DW'(1'b0));
    chk("rst.last", DW'(m_axis_tlast), DW'(1'b0));
    chk("rst.data", m_axis_tdata, DW'(0));
    chk("rst.tid", DW'(m_axis_tid), DW'(0));
    chk("rst.wgt", DW'(m_weight), DW'(0));
    chk("rst.tready", DW'(s_axis_tready), DW'(0));
    chk("rst.busy", DW'(busy), DW'(0));
    chk("rst.pkt", DW'(pkt_count), DW'(0));
    resetn = 1'b1;
    tick();

    // Single 3-beat packet from source 2 with weight 0x40
    wgt_wr_en = 1'b1; wgt_wr_idx = 2'd2; wgt_wr_data = 8'h40;
    tick();
    wgt_wr_en = 1'b0;
    start_pkt(2, 3);
    #1;
    chk("t1.idle_tready", DW'(s_axis_tready), DW'(4'b0000));
    tick();
    chk("t1.busy", DW'(busy), DW'(1));
    chk("t1.tready", DW'(s_axis_tready), DW'(4'b0100));
    chk("t1.novalid", DW'(m_axis_tvalid), DW'(0));
    tick();
    chk_out("t1.b0", 16'h0200, 1'b0, 2'd2, 8'h40);
    tick();
    chk_out("t1.b1", 16'h0201, 1'b0, 2'd2, 8'h40);
    tick();
    chk_out("t1.b2", 16'h0202, 1'b1, 2'd2, 8'h40);
    chk("t1.pkt", DW'(pkt_count), DW'(1));
    chk("t1.idle", DW'(busy), DW'(0));
    tick();
    chk("t1.drain", DW'(m_axis_tvalid), DW'(0));

    // Reset so round-robin restarts at source 0; weights return to 0
    resetn = 1'b0;
    clear_srcs();
    tick();
    resetn = 1'b1;
    tick();

    // Sources 0, 1, 3 each with a 2-beat packet
    start_pkt(0, 2);
    start_pkt(1, 2);
    start_pkt(3, 2);
    tick();
    chk("t2.g0", DW'(s_axis_tready), DW'(4'b0001));
    tick();
    chk_out("t2.s0b0", 16'h0000, 1'b0, 2'd0, 8'h00);
    chk("t2.rdy0", DW'(s_axis_tready), DW'(4'b0001));
    tick();
    chk_out("t2.s0b1", 16'h0001, 1'b1, 2'd0, 8'h00);
    chk("t2.bubble0", DW'(s_axis_tready), DW'(4'b0000));
    tick();
    chk("t2.g1", DW'(s_axis_tready), DW'(4'b0010));
    chk("t2.drain0", DW'(m_axis_tvalid), DW'(0));
    tick();
    chk_out("t2.s1b0", 16'h0100, 1'b0, 2'd1, 8'h00);
    tick();
    chk_out("t2.s1b1", 16'h0101, 1'b1, 2'd1, 8'h00);
    chk("t2.bubble1", DW'(s_axis_tready), DW'(4'b0000));
    tick();
    chk("t2.g3", DW'(s_axis_tready), DW'(4'b1000));
    tick();
    chk_out("t2.s3b0", 16'h0300, 1'b0, 2'd3, 8'h00);
    tick();
    chk_out("t2.s3b1", 16'h0301, 1'b1, 2'd3, 8'h00);
    chk("t2.pkt", DW'(pkt_count), DW'(3));

    // 4-beat packet from source 1 with output stall
    start_pkt(1, 4);
    tick();
    chk("t3.g1", DW'(s_axis_tready), DW'(4'b0010));
    tick();
    chk_out("t3.b0", 16'h0102, 1'b0, 2'd1, 8'h00);
    m_axis_tready = 1'b0;
    #1;
    chk("t3.stall_rdy", DW'(s_axis_tready), DW'(4'b0000));
    tick();
    chk_out("t3.hold1", 16'h0102, 1'b0, 2'd1, 8'h00);
    tick();
    chk_out("t3.hold2", 16'h0102, 1'b0, 2'd1, 8'h00);
    m_axis_tready = 1'b1;
    #1;
    chk("t3.resume_rdy", DW'(s_axis_tready), DW'(4'b0010));
    tick();
    chk_out("t3.b1", 16'h0103, 1'b0, 2'd1, 8'h00);
    tick();
    chk_out("t3.b2", 16'h0104, 1'b0, 2'd1, 8'h00);
    tick();
    chk_out("t3.b3", 16'h0105, 1'b1, 2'd1, 8'h00);
    chk("t3.pkt", DW'(pkt_count), DW'(4));

    // Weight writes: mid-packet and in the grant cycle
    wgt_wr_en = 1'b1; wgt_wr_idx = 2'd1; wgt_wr_data = 8'h10;
    tick();
    wgt_wr_en = 1'b0;
    start_pkt(1, 3);
    tick();
    tick();
    chk_out("t4.b0", 16'h0106, 1'b0, 2'd1, 8'h10);
    wgt_wr_en = 1'b1; wgt_wr_data = 8'h20;
    tick();
    wgt_wr_en = 1'b0;
    chk_out("t4.b1", 16'h0107, 1'b0, 2'd1, 8'h10);
    tick();
    chk_out("t4.b2", 16'h0108, 1'b1, 2'd1, 8'h10);
    start_pkt(1, 1);
    tick();
    tick();
    chk_out("t4.next", 16'h0109, 1'b1, 2'd1, 8'h20);
    start_pkt(1, 1);
    wgt_wr_en = 1'b1; wgt_wr_data = 8'h30;
    tick();
    wgt_wr_en = 1'b0;
    tick();
    chk_out("t4.samecyc", 16'h010a, 1'b1, 2'd1, 8'h20);
    chk("t4.pkt", DW'(pkt_count), DW'(7));

    // Source 0 streams 1-beat packets; source 3 must not starve
    rpt[0] = 1'b1;
    start_pkt(0, 1);
    tick();
    chk("t6.g0", DW'(s_axis_tready), DW'(4'b0001));
    start_pkt(3, 1);
    tick();
    chk_out("t6.s0", 16'h0002, 1'b1, 2'd0, 8'h00);
    tick();
    chk("t6.g3", DW'(s_axis_tready), DW'(4'b1000));
    tick();
    chk_out("t6.s3", 16'h0302, 1'b1, 2'd3, 8'h00);
    clear_srcs();
    tick();

    // Asynchronous reset in the middle of a packet
    start_pkt(2, 3);
    tick();
    tick();
    chk_out("t5.b0", 16'h0203, 1'b0, 2'd2, 8'h00);
    resetn = 1'b0;
    #1;
    chk("t5.valid", DW'(m_axis_tvalid), DW'(0));
    chk("t5.data", m_axis_tdata, DW'(0));
    chk("t5.tid", DW'(m_axis_tid), DW'(0));
    chk("t5.busy", DW'(busy), DW'(0));
    chk("t5.pkt", DW'(pkt_count), DW'(0));
    chk("t5.tready", DW'(s_axis_tready), DW'(0));
    start_pkt(0, 1);
    #1 resetn = 1'b1;
    tick();
    chk("t5.g0", DW'(s_axis_tready), DW'(4'b0001));
    tick();
    chk_out("t5.s0", 16'h0003, 1'b1, 2'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
